// File: rtl/fluid_mux_pkg.sv
// Shared types and helpers for the binary-tree fluid multiplexer controller.
// Valve line convention: 1 = pressurised = closed.
package fluid_mux_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISOLATE,
    SETTLE,
    DWELL,
    DRAIN
  } state_t;

  localparam int MAX_LEVELS = 16;
  localparam logic [2*MAX_LEVELS-1:0] CTRL_CLOSED = '1;

  // Open exactly one branch per used level; unused levels stay closed.
  function automatic logic [2*MAX_LEVELS-1:0] sel_to_ctrl(input logic [MAX_LEVELS-1:0] sel,
                                                          input int levels);
    logic [2*MAX_LEVELS-1:0] c;
    c = CTRL_CLOSED;
    for (int l = 0; l < MAX_LEVELS; l++) begin
      if (l < levels) c[2*l + int'(sel[l])] = 1'b0;
    end
    return c;
  endfunction

endpackage

// File: rtl/fluid_mux_path_decode.sv
// Combinational selection-to-valve decode for one binary mux tree.
// Each level vents the branch named by its select bit and pressurises the other.
module fluid_mux_path_decode #(
  parameter int LEVELS = 3
) (
  input  logic [LEVELS-1:0]   sel,
  output logic [2*LEVELS-1:0] ctrl
);

  generate
    for (genvar gi = 0; gi < LEVELS; gi++) begin : g_level
      assign ctrl[2*gi]   = sel[gi];
      assign ctrl[2*gi+1] = ~sel[gi];
    end
  endgenerate

endmodule

// File: rtl/fluid_mux_sequencer.sv
// Break-before-make valve sequencer: isolate, drive path, settle, dwell, drain.
// A single down-counter times every phase; it never wraps below zero.
module fluid_mux_sequencer
  import fluid_mux_pkg::*;
#(
  parameter int LEVELS        = 3,
  parameter int CLOSE_CYCLES  = 16,
  parameter int SETTLE_CYCLES = 32,
  parameter int DWELL_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [LEVELS-1:0]   req_sel,
  input  logic [DWELL_W-1:0]  req_dwell,
  input  logic                abort,
  output logic [2*LEVELS-1:0] ctrl,
  output logic                path_open,
  output logic [LEVELS-1:0]   cur_sel,
  output logic                busy,
  output logic                done,
  output logic                aborted
);

  localparam logic [DWELL_W-1:0] CLOSE_LOAD  = DWELL_W'(CLOSE_CYCLES - 1);
  localparam logic [DWELL_W-1:0] SETTLE_LOAD = DWELL_W'(SETTLE_CYCLES - 1);
  localparam logic [2*LEVELS-1:0] ALL_CLOSED = CTRL_CLOSED[2*LEVELS-1:0];

  state_t             state_reg, state_next;
  logic [DWELL_W-1:0] timer_reg, timer_next;
  logic [DWELL_W-1:0] dwell_reg, dwell_next;
  logic [LEVELS-1:0]  sel_reg, sel_next;
  logic               abort_flag_reg, abort_flag_next;
  logic               done_reg, done_next;
  logic               aborted_reg, aborted_next;
  logic [2*LEVELS-1:0] path_ctrl;

  fluid_mux_path_decode #(
    .LEVELS(LEVELS)
  ) u_decode (
    .sel (sel_reg),
    .ctrl(path_ctrl)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      timer_reg      <= '0;
      dwell_reg      <= '0;
      sel_reg        <= '0;
      abort_flag_reg <= 1'b0;
      done_reg       <= 1'b0;
      aborted_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      dwell_reg      <= dwell_next;
      sel_reg        <= sel_next;
      abort_flag_reg <= abort_flag_next;
      done_reg       <= done_next;
      aborted_reg    <= aborted_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    timer_next      = (timer_reg != '0) ? timer_reg - DWELL_W'(1) : timer_reg;
    dwell_next      = dwell_reg;
    sel_next        = sel_reg;
    abort_flag_next = abort_flag_reg;
    done_next       = 1'b0;
    aborted_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          state_next      = ISOLATE;
          timer_next      = CLOSE_LOAD;
          sel_next        = req_sel;
          dwell_next      = req_dwell;
          abort_flag_next = 1'b0;
        end
      end
      ISOLATE, SETTLE, DWELL: begin
        // Abort wins over a timer expiry in the same cycle.
        if (abort) begin
          state_next      = DRAIN;
          timer_next      = CLOSE_LOAD;
          abort_flag_next = 1'b1;
        end else if (state_reg == ISOLATE) begin
          if (timer_reg == '0) begin
            state_next = SETTLE;
            timer_next = SETTLE_LOAD;
          end
        end else if (state_reg == SETTLE) begin
          if (timer_reg == '0) begin
            state_next = DWELL;
            timer_next = (dwell_reg == '0) ? '0 : dwell_reg - DWELL_W'(1);
          end
        end else begin
          // Zero dwell means hold the path open until aborted.
          if (dwell_reg != '0 && timer_reg == '0) begin
            state_next = DRAIN;
            timer_next = CLOSE_LOAD;
          end
        end
      end
      DRAIN: begin
        if (abort) abort_flag_next = 1'b1;
        if (timer_reg == '0) begin
          state_next      = IDLE;
          done_next       = ~(abort_flag_reg | abort);
          aborted_next    = abort_flag_reg | abort;
          abort_flag_next = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign ctrl      = (state_reg == SETTLE || state_reg == DWELL) ? path_ctrl : ALL_CLOSED;
  assign path_open = (state_reg == DWELL);
  assign req_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign cur_sel   = sel_reg;
  assign done      = done_reg;
  assign aborted   = aborted_reg;

endmodule

// File: tb/tb_fluid_mux_sequencer.sv
// Bench for fluid_mux_sequencer: phase-timeline model plus directed literal checks.
module tb_fluid_mux_sequencer;

  localparam int L  = 3;
  localparam int C  = 4;
  localparam int S  = 6;
  localparam int DW = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [L-1:0]   req_sel = '0;
  logic [DW-1:0]  req_dwell = '0;
  logic           abort = 1'b0;
  logic [2*L-1:0] ctrl;
  logic           path_open;
  logic [L-1:0]   cur_sel;
  logic           busy;
  logic           done;
  logic           aborted;

  int tests = 0;
  int fails = 0;

  fluid_mux_sequencer #(
    .LEVELS(L), .CLOSE_CYCLES(C), .SETTLE_CYCLES(S), .DWELL_W(DW)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_dwell(req_dwell), .abort(abort), .ctrl(ctrl),
    .path_open(path_open), .cur_sel(cur_sel), .busy(busy), .done(done),
    .aborted(aborted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // n counts cycles since the accept cycle; phases follow from fixed durations.
  int         m_active = 0;
  int         m_n = 0;
  int         m_abend = -1;
  int         m_dwell = 0;
  logic [L-1:0] m_sel = '0;
  bit         m_flag = 0;
  bit         m_done = 0;
  bit         m_abp = 0;

  // 1 isolate, 2 settle, 3 dwell, 4 drain
  function automatic int phase_of(input int n);
    if (m_abend >= 0 && n > m_abend - C) return 4;
    if (n <= C) return 1;
    if (n <= C + S) return 2;
    if (m_dwell == 0 || n <= C + S + m_dwell) return 3;
    return 4;
  endfunction

  function automatic int last_n();
    if (m_abend >= 0) return m_abend;
    if (m_dwell == 0) return 1 << 30;
    return 2 * C + S + m_dwell;
  endfunction

  function automatic logic [2*L-1:0] open_pattern(input logic [L-1:0] sel);
    logic [2*L-1:0] p;
    for (int l = 0; l < L; l++) p[2*l +: 2] = sel[l] ? 2'b01 : 2'b10;
    return p;
  endfunction

  always @(posedge clk) begin
    int ph;
    m_done = 0;
    m_abp  = 0;
    if (rst) begin
      m_active = 0;
      m_sel    = '0;
    end else if (m_active != 0) begin
      ph = phase_of(m_n);
      if (abort) begin
        m_flag = 1;
        if (ph != 4) m_abend = m_n + C;
      end
      if (m_n >= last_n()) begin
        m_active = 0;
        if (m_flag) m_abp = 1;
        else m_done = 1;
      end else begin
        m_n++;
      end
    end else if (req_valid) begin
      m_active = 1;
      m_n      = 1;
      m_sel    = req_sel;
      m_dwell  = int'(req_dwell);
      m_flag   = 0;
      m_abend  = -1;
      $display("[TB] accept sel=%0d dwell=%0d at %0t", req_sel, req_dwell, $time);
    end
  end

  // Compare process: every non-reset cycle, all outputs against the model.
  always @(negedge clk) begin
    logic [2*L-1:0] e_ctrl;
    logic           e_open;
    logic [31:0]    act, exp;
    int             ph;
    if (!rst) begin
      e_ctrl = '1;
      e_open = 1'b0;
      if (m_active != 0) begin
        ph = phase_of(m_n);
        if (ph == 2 || ph == 3) e_ctrl = open_pattern(m_sel);
        e_open = (ph == 3);
      end
      act = 32'({ctrl, path_open, req_ready, busy, done, aborted, cur_sel});
      exp = 32'({e_ctrl, e_open, (m_active == 0), (m_active != 0), m_done, m_abp, m_sel});
      chk("cycle_model", act, exp);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 600) begin
      step();
      k++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
    step();
  endtask

  logic [5:0] tbl [8] = '{6'b101010, 6'b101001, 6'b100110, 6'b100101,
                          6'b011010, 6'b011001, 6'b010110, 6'b010101};

  initial begin
    int zeros;
    int r;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("reset_ctrl", 32'(ctrl), 32'h3f);
    chk("reset_ready", 32'(req_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);

    // Normal sequence sel=5 dwell=3, accept in cycle T.
    req_sel = 3'd5; req_dwell = 8'd3; req_valid = 1'b1;
    step(); req_valid = 1'b0;                          // T+1
    chk("n_iso_first", 32'(ctrl), 32'h3f);
    repeat (3) step(); chk("n_iso_last", 32'(ctrl), 32'h3f);   // T+4
    step(); chk("n_settle_first", 32'(ctrl), 32'(6'b011001));  // T+5
    chk("n_settle_open", 32'(path_open), 32'd0);
    repeat (6) step(); chk("n_dwell_first", 32'(path_open), 32'd1); // T+11
    chk("n_dwell_ctrl", 32'(ctrl), 32'(6'b011001));
    repeat (2) step(); chk("n_dwell_last", 32'(path_open), 32'd1); // T+13
    step(); chk("n_drain_ctrl", 32'(ctrl), 32'h3f);           // T+14
    repeat (3) step(); chk("n_drain_last_done", 32'(done), 32'd0); // T+17
    step(); chk("n_done", 32'(done), 32'd1);                  // T+18
    step(); chk("n_done_clear", 32'(done), 32'd0);

    // Hold-until-abort with sel=0.
    wait_idle();
    req_sel = 3'd0; req_dwell = 8'd0; req_valid = 1'b1;
    step(); req_valid = 1'b0;
    repeat (C + S + 99) step();                               // X
    chk("hold_ctrl", 32'(ctrl), 32'(6'b101010));
    chk("hold_open", 32'(path_open), 32'd1);
    abort = 1'b1;
    step(); abort = 1'b0;                                     // X+1
    chk("hold_abort_ctrl", 32'(ctrl), 32'h3f);
    repeat (4) step();                                        // X+5
    chk("hold_aborted", 32'(aborted), 32'd1);
    chk("hold_no_done", 32'(done), 32'd0);

    // Abort on the settle-expiry cycle.
    wait_idle();
    req_sel = 3'd3; req_dwell = 8'd5; req_valid = 1'b1;
    step(); req_valid = 1'b0;                                 // T+1
    repeat (9) step();                                        // T+10
    abort = 1'b1;
    step(); abort = 1'b0;                                     // T+11
    chk("se_abort_ctrl", 32'(ctrl), 32'h3f);
    chk("se_abort_open", 32'(path_open), 32'd0);
    repeat (4) step();                                        // T+15
    chk("se_aborted", 32'(aborted), 32'd1);

    // req_valid held across completion.
    wait_idle();
    req_sel = 3'd2; req_dwell = 8'd2; req_valid = 1'b1;
    step(); req_sel = 3'd6;                                   // T+1
    chk("b2b_ready_low", 32'(req_ready), 32'd0);
    chk("b2b_cur_sel", 32'(cur_sel), 32'd2);
    repeat (15) step();                                       // T+16
    chk("b2b_pre_done", 32'(done), 32'd0);
    step();                                                   // T+17
    chk("b2b_done", 32'(done), 32'd1);
    chk("b2b_ready", 32'(req_ready), 32'd1);
    step(); req_valid = 1'b0;                                 // T+18
    chk("b2b_second_busy", 32'(busy), 32'd1);
    chk("b2b_second_sel", 32'(cur_sel), 32'd6);
    chk("b2b_second_ctrl", 32'(ctrl), 32'h3f);

    // Sweep every selection.
    for (int s = 0; s < 8; s++) begin
      wait_idle();
      req_sel = 3'(s); req_dwell = 8'd1; req_valid = 1'b1;
      step(); req_valid = 1'b0;
      repeat (C + S) step();
      zeros = 0;
      for (int l = 0; l < L; l++) zeros += (ctrl[2*l +: 2] == 2'b01 || ctrl[2*l +: 2] == 2'b10) ? 1 : 0;
      chk("sweep_one_zero_per_pair", 32'(zeros), 32'(L));
      chk("sweep_pattern", 32'(ctrl), 32'(tbl[s]));
    end

    // Randomised traffic against the model.
    wait_idle();
    for (int i = 0; i < 6000; i++) begin
      step();
      req_valid = ($urandom % 4) == 0;
      req_sel   = 3'($urandom);
      r = $urandom % 16;
      req_dwell = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : 8'($urandom_range(1, 6));
      abort     = ($urandom % 60) == 0;
      rst       = ($urandom % 800) == 0;
    end
    req_valid = 1'b0; abort = 1'b0; rst = 1'b0;
    repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fluid_mux_sequencer.md
Name: fluid_mux_sequencer

Overview:
- Timed pneumatic controller for a parametrised 2^LEVELS:1 binary-tree fluid multiplexer. The tree is the generalisation of the fixed 8:1 mux: LEVELS valve stages, with one control-line pair per stage.
- Accepts a path request and sequences valves break-before-make: isolate, open path, settle, dwell, drain back to all-closed.
- Sits between the chip-level protocol controller and the solenoid driver bank.

Parameters:
- LEVELS, 3, tree depth; number of fluid inputs = 2^LEVELS; control lines = 2*LEVELS.
- CLOSE_CYCLES, 16, cycles all valves held closed before opening a path and after releasing it. Range 1..2^DWELL_W-1.
- SETTLE_CYCLES, 32, cycles the path is driven before it is declared open. Range 1..2^DWELL_W-1.
- DWELL_W, 16, width of the dwell request and of the shared phase timer.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  path request valid.
- req_ready  out  1  high only in IDLE.
- req_sel  in  LEVELS  selected input index. Bit l steers level l; level 0 is the input-side stage.
- req_dwell  in  DWELL_W  open-path hold time in cycles; 0 = hold until abort.
- abort  in  1  terminate the current sequence and close the tree.
- ctrl  out  2*LEVELS  valve air lines; 1 = pressurised = valve closed. ctrl[2l] closes the sel-bit-0 branch of level l, ctrl[2l+1] closes the sel-bit-1 branch.
- path_open  out  1  high during DWELL.
- cur_sel  out  LEVELS  latched selection.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse on completion after an abort.

Behaviour:
- Reset: state IDLE, ctrl all ones, cur_sel 0, timer 0, path_open/busy/done/aborted 0, req_ready 1. Reset mid-sequence closes all valves in the next cycle.
- Handshake: a request is accepted on a clock edge with req_valid && req_ready. On accept, req_sel and req_dwell are latched. req_ready is never high outside IDLE, so back-to-back requests are separated by at least one IDLE cycle.
- IDLE: ctrl all ones. On accept, go to ISOLATE and load timer = CLOSE_CYCLES-1.
- ISOLATE: ctrl all ones. When the timer reaches 0, go to SETTLE and load timer = SETTLE_CYCLES-1.
- SETTLE: ctrl = decode(cur_sel). For each level l: ctrl[2l+cur_sel[l]] = 0 and ctrl[2l+!cur_sel[l]] = 1. When the timer reaches 0, go to DWELL and load timer = dwell-1.
- DWELL: ctrl = decode(cur_sel), path_open = 1.
  - dwell != 0: when the timer reaches 0, go to DRAIN.
  - dwell == 0: stay in DWELL until abort.
- DRAIN: ctrl all ones. Timer starts at CLOSE_CYCLES-1. When it reaches 0, go to IDLE and pulse done, or pulse aborted if an abort was recorded.
- Abort:
  - In ISOLATE, SETTLE or DWELL: next state DRAIN, timer reloaded, abort flag set.
  - In DRAIN: flag set only; the timer is not restarted.
  - In IDLE: ignored.
  - Abort outranks a same-cycle timer expiry.
- Latency (normal): accept edge T. ISOLATE covers cycles T+1..T+C, SETTLE the next S cycles, DWELL the next D cycles, DRAIN the next C cycles. done is high in the first IDLE cycle, T+2C+S+D+1.
- Never more than one open branch per level; every ctrl transition from one path to another passes through all-ones.
- Timer is a DWELL_W-bit down-counter and does not wrap. req_dwell = 2^DWELL_W-1 is valid.

Decomposition:
- Package fluid_mux_pkg: state enum (IDLE, ISOLATE, SETTLE, DWELL, DRAIN), CTRL_CLOSED constant helper, function sel_to_ctrl(sel, LEVELS).
- Sub-module fluid_mux_path_decode: combinational sel -> 2*LEVELS ctrl pattern. It is reusable by a future multi-tree controller.
- FSM and timer stay in the top module.

Test Plan (LEVELS=3, CLOSE_CYCLES=4, SETTLE_CYCLES=6, DWELL_W=8):
- Reset held 3 cycles, then released -> ctrl=6'b111111, req_ready=1, busy=0, done=0.
- req_sel=5, req_dwell=3, accepted at T:
  - ctrl=111111 for T+1..T+4.
  - ctrl=6'b011001 for T+5..T+13, with path_open=1 for T+11..T+13.
  - ctrl=111111 for T+14..T+17.
  - done=1 only at T+18.
- req_sel=0, req_dwell=0 -> ctrl=6'b101010 and path_open held for 100 cycles. abort at cycle X -> ctrl=111111 at X+1, aborted pulse at X+5, no done.
- abort asserted in SETTLE on the same cycle the timer expires -> goes to DRAIN, path_open never asserted, aborted pulse.
- req_valid held high across a completion -> second accept occurs only in the IDLE cycle after done. ctrl is all ones between the two paths.
- Sweep req_sel 0..7 -> each ctrl pattern has exactly one zero per pair, and the pattern matches sel_to_ctrl.
